// File: rtl/nibble_asm_pkg.sv
// Shared types and helpers for the nibble assembler: accumulator states,
// the out_count width rule and the beat-to-bit-offset mapping.
package nibble_asm_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } asm_state_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) w = w + 1;
    return w;
  endfunction

  // Low bit of beat k inside a word of n beats, each in_w bits wide.
  function automatic int pack_off(input int k, input bit msb_first,
                                  input int in_w, input int n);
    return msb_first ? (n - 1 - k) * in_w : k * in_w;
  endfunction

endpackage

// File: rtl/nibble_asm_outreg.sv
// Single-entry valid/ready holding register for {count, data}. The producer
// only loads when the slot is free, so a held word never changes under stall.
module nibble_asm_outreg #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      count_q <= count_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/nibble_assembler.sv
// Packs a no-backpressure beat stream into NIBBLES-beat words on a valid/ready
// output. Optional drop counter enabled by NIBBLE_ASM_DROP_CNT_EN.
//
// state | meaning
// EMPTY | no beats held (fill = 0)
// ACCUM | partial word, 0 < fill < NIBBLES
// FULL  | complete word waiting for the output slot; new beats are dropped
module nibble_assembler
  import nibble_asm_pkg::*;
#(
  parameter int IN_W       = 4,
  parameter int NIBBLES    = 4,
  parameter int MSB_FIRST  = 1,
  parameter int DROP_CNT_W = 8,
  localparam int OUT_W     = IN_W * NIBBLES,
  localparam int CNT_W     = cnt_width(NIBBLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             flush,
  input  logic             ovf_clr,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
`ifdef NIBBLE_ASM_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0] drop_count,
`endif
  output logic             overflow,
  output logic             busy
);

  asm_state_e       state_q, state_d;
  logic [CNT_W-1:0] fill_q, fill_d, fill_app;
  logic [OUT_W-1:0] acc_q, acc_d, acc_app, acc_fresh;
  logic             flush_pend_q, flush_pend_d;
  logic             overflow_q, overflow_d;
  logic             slot_free, drop;
  logic             load;
  logic [OUT_W-1:0] load_data;
  logic [CNT_W-1:0] load_count;

  assign slot_free = !out_valid || out_ready;
  assign fill_app  = fill_q + CNT_W'(1);

  always_comb begin
    acc_app   = acc_q;
    acc_fresh = '0;
    acc_fresh[pack_off(0, MSB_FIRST != 0, IN_W, NIBBLES) +: IN_W] = in_data;
    for (int k = 0; k < NIBBLES; k++) begin
      if (fill_q == CNT_W'(k))
        acc_app[pack_off(k, MSB_FIRST != 0, IN_W, NIBBLES) +: IN_W] = in_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    acc_d        = acc_q;
    flush_pend_d = flush_pend_q;
    load         = 1'b0;
    load_data    = acc_q;
    load_count   = fill_q;
    drop         = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          acc_d   = acc_fresh;
          fill_d  = CNT_W'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d  = acc_app;
          fill_d = fill_app;
        end
        if (flush) flush_pend_d = 1'b1;
        if (in_valid && fill_app == CNT_W'(NIBBLES)) begin
          // A completed word always goes out as a full word, pending flush or not.
          flush_pend_d = 1'b0;
          if (slot_free) begin
            load       = 1'b1;
            load_data  = acc_app;
            load_count = CNT_W'(NIBBLES);
            acc_d      = '0;
            fill_d     = '0;
            state_d    = EMPTY;
          end else begin
            state_d = FULL;
          end
        end else if (flush_pend_q && slot_free) begin
          load         = 1'b1;
          load_data    = acc_d;
          load_count   = fill_d;
          acc_d        = '0;
          fill_d       = '0;
          flush_pend_d = 1'b0;
          state_d      = EMPTY;
        end
      end
      FULL: begin
        if (slot_free) begin
          load       = 1'b1;
          load_data  = acc_q;
          load_count = CNT_W'(NIBBLES);
          if (in_valid) begin
            acc_d   = acc_fresh;
            fill_d  = CNT_W'(1);
            state_d = ACCUM;
          end else begin
            acc_d   = '0;
            fill_d  = '0;
            state_d = EMPTY;
          end
        end else if (in_valid) begin
          drop = 1'b1;
        end
      end
      default: begin
        acc_d   = '0;
        fill_d  = '0;
        state_d = EMPTY;
      end
    endcase
  end

  assign overflow_d = drop || (overflow_q && !ovf_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      fill_q       <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      acc_q        <= acc_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
    end
  end

  nibble_asm_outreg #(
    .DATA_W (OUT_W),
    .CNT_W  (CNT_W)
  ) u_outreg (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load),
    .data_i  (load_data),
    .count_i (load_count),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .count_o (out_count)
  );

`ifdef NIBBLE_ASM_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (ovf_clr)          drop_cnt_d = DROP_CNT_W'(1);
      else if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end else if (ovf_clr) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

  assign overflow = overflow_q;
  assign busy     = (fill_q != '0) || out_valid;

endmodule

// File: tb/tb_nibble_assembler.sv
// Directed bench for nibble_assembler: an MSB-first and an LSB-first instance
// share one stimulus stream; transferred words are logged at the falling edge.
module tb_nibble_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, flush, ovf_clr, out_ready;
  logic [3:0]  in_data;
  logic [15:0] m_data, l_data;
  logic        m_valid, l_valid, m_ovf, l_ovf, m_busy, l_busy;
  logic [2:0]  m_cnt, l_cnt;
`ifdef NIBBLE_ASM_DROP_CNT_EN
  logic [7:0]  m_drop, l_drop;
`endif

  nibble_assembler #(.IN_W(4), .NIBBLES(4), .MSB_FIRST(1), .DROP_CNT_W(8)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .flush(flush), .ovf_clr(ovf_clr), .out_data(m_data), .out_valid(m_valid),
    .out_ready(out_ready), .out_count(m_cnt),
`ifdef NIBBLE_ASM_DROP_CNT_EN
    .drop_count(m_drop),
`endif
    .overflow(m_ovf), .busy(m_busy)
  );

  nibble_assembler #(.IN_W(4), .NIBBLES(4), .MSB_FIRST(0), .DROP_CNT_W(8)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .flush(flush), .ovf_clr(ovf_clr), .out_data(l_data), .out_valid(l_valid),
    .out_ready(out_ready), .out_count(l_cnt),
`ifdef NIBBLE_ASM_DROP_CNT_EN
    .drop_count(l_drop),
`endif
    .overflow(l_ovf), .busy(l_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] m_wq[$], l_wq[$];
  logic [2:0]  m_cq[$], l_cq[$];

  always @(negedge clk) begin
    if (!rst && m_valid && out_ready) begin
      m_wq.push_back(m_data);
      m_cq.push_back(m_cnt);
    end
    if (!rst && l_valid && out_ready) begin
      l_wq.push_back(l_data);
      l_cq.push_back(l_cnt);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic f, input logic c);
    in_valid = v;
    in_data  = d;
    flush    = f;
    ovf_clr  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    flush    = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic beat(input logic [3:0] d);
    drive(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic clearq();
    m_wq.delete();
    m_cq.delete();
    l_wq.delete();
    l_cq.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0;
    flush = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data",  32'(m_data),  32'd0);
    check("rst_count", 32'(m_cnt),   32'd0);
    check("rst_ovf",   32'(m_ovf),   32'd0);
    check("rst_busy",  32'(m_busy),  32'd0);
    rst = 1'b0;

    // basic pack, one-cycle latency and single-cycle pulse
    clearq();
    beat(4'h1); beat(4'h2); beat(4'h3);
    check("t1_not_early", 32'(m_valid), 32'd0);
    beat(4'h4);
    check("t1_valid", 32'(m_valid), 32'd1);
    check("t1_data",  32'(m_data),  32'h1234);
    check("t1_count", 32'(m_cnt),   32'd4);
    idle(1);
    check("t1_pulse", 32'(m_valid), 32'd0);
    check("t1_nwords", 32'(m_wq.size()), 32'd1);

    // backpressure, FULL, drop
    clearq();
    out_ready = 1'b0;
    beat(4'hA); beat(4'hB); beat(4'hC); beat(4'hD);
    beat(4'hE); beat(4'hF); beat(4'h0); beat(4'h1);
    check("t2_ovf_before", 32'(m_ovf), 32'd0);
    beat(4'h5);
    check("t2_hold_data", 32'(m_data),  32'hABCD);
    check("t2_hold_vld",  32'(m_valid), 32'd1);
    check("t2_ovf",       32'(m_ovf),   32'd1);
    check("t2_busy",      32'(m_busy),  32'd1);
`ifdef NIBBLE_ASM_DROP_CNT_EN
    check("t2_dropcnt", 32'(m_drop), 32'd1);
`endif
    out_ready = 1'b1;
    idle(3);
    check("t2_nwords", 32'(m_wq.size()), 32'd2);
    check("t2_word0",  32'(m_wq[0]), 32'hABCD);
    check("t2_word1",  32'(m_wq[1]), 32'hEF01);
    check("t2_idle_busy", 32'(m_busy), 32'd0);

    // overflow clear, then drop coincident with clear
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    check("t5_ovf_clr", 32'(m_ovf), 32'd0);
`ifdef NIBBLE_ASM_DROP_CNT_EN
    check("t5_dropcnt_clr", 32'(m_drop), 32'd0);
`endif
    clearq();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) beat(4'(i));
    drive(1'b1, 4'h9, 1'b0, 1'b1);
    check("t5_ovf_same", 32'(m_ovf), 32'd1);
`ifdef NIBBLE_ASM_DROP_CNT_EN
    check("t5_dropcnt_same", 32'(m_drop), 32'd1);
`endif
    out_ready = 1'b1;
    idle(3);
    check("t5_nwords", 32'(m_wq.size()), 32'd2);
    check("t5_word1",  32'(m_wq[1]), 32'h5678);
    drive(1'b0, 4'h0, 1'b0, 1'b1);

    // flush partial, flush when empty, flush with coincident beat
    clearq();
    beat(4'h7); beat(4'h8);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    idle(3);
    check("t3_nwords", 32'(m_wq.size()), 32'd1);
    check("t3_data",   32'(m_wq[0]), 32'h7800);
    check("t3_count",  32'(m_cq[0]), 32'd2);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    idle(3);
    check("t3_empty_flush", 32'(m_wq.size()), 32'd1);
    beat(4'h1); beat(4'h2);
    drive(1'b1, 4'h9, 1'b1, 1'b0);
    idle(3);
    check("t3_nwords2", 32'(m_wq.size()), 32'd2);
    check("t3_data2",   32'(m_wq[1]), 32'h1290);
    check("t3_count2",  32'(m_cq[1]), 32'd3);
    check("t3_busy",    32'(m_busy),  32'd0);

    // reset mid-word discards the partial word
    clearq();
    beat(4'h1); beat(4'h2); beat(4'h3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t4_busy_after_rst", 32'(m_busy), 32'd0);
    beat(4'hC); beat(4'hD); beat(4'hE); beat(4'hF);
    idle(2);
    check("t4_nwords", 32'(m_wq.size()), 32'd1);
    check("t4_data",   32'(m_wq[0]), 32'hCDEF);
    check("t4_count",  32'(m_cq[0]), 32'd4);

    // LSB-first ordering
    clearq();
    beat(4'h1); beat(4'h2); beat(4'h3); beat(4'h4);
    idle(1);
    beat(4'h1); beat(4'h2);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    idle(3);
    check("t6_nwords", 32'(l_wq.size()), 32'd2);
    check("t6_full",   32'(l_wq[0]), 32'h4321);
    check("t6_fcount", 32'(l_cq[0]), 32'd4);
    check("t6_part",   32'(l_wq[1]), 32'h0021);
    check("t6_pcount", 32'(l_cq[1]), 32'd2);
    check("t6_msb_part", 32'(m_wq[1]), 32'h1200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_assembler.md
Name: nibble_assembler

Overview:
- Downstream consumer of `submod`. Takes the 4-bit `data_bus` and `valid` stream and packs consecutive nibbles into wider words.
- Presents the packed words on a valid/ready output.
- The input side has no backpressure, because `submod` exposes no ready. The block therefore accepts every beat it can, and drops and flags any beat it cannot hold.

Parameters:
- IN_W, 4, input beat width in bits (matches `data_bus`).
- NIBBLES, 4, beats per output word. OUT_W = IN_W*NIBBLES. Legal range is 2..16.
- MSB_FIRST, 1, set to 1 to place the first beat in the top slice of the word; set to 0 to place it in the bottom slice.
- DROP_CNT_W, 8, width of the drop counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  IN_W  beat from `submod.data_bus`.
- in_valid  in  1  beat qualifier from `submod.valid`.
- flush  in  1  single-cycle pulse; emits the partial word.
- ovf_clr  in  1  clears the sticky overflow flag.
- out_data  out  OUT_W  packed word.
- out_valid  out  1  word available.
- out_ready  in  1  downstream accepts the word.
- out_count  out  clog2(NIBBLES+1)  number of valid beats in `out_data`.
- overflow  out  1  sticky flag; set when a beat is dropped.
- busy  out  1  high when the accumulator or output register holds data.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - Outputs: out_data=0, out_valid=0, out_count=0, overflow=0, busy=0.
  - Internal: fill=0, flush_pend=0, state=EMPTY.
  - Any partial word or pending word is discarded. Reset takes priority over all other inputs.
- Storage:
  - An accumulator holds up to NIBBLES beats, with fill count `fill`.
  - A single-entry output register holds the word that is presented downstream.
  - "Slot free" means !out_valid || out_ready.
- Accumulator state machine:
  - EMPTY (fill=0): on in_valid, store the beat and go to ACCUM. If NIBBLES would be reached, use the completion rule below.
  - ACCUM (0<fill<NIBBLES): on in_valid, append the beat.
    - When the beat completes the word and the slot is free: the word is loaded into the output register at the next edge, fill returns to 0, and the state goes to EMPTY.
    - When the beat completes the word and the slot is not free: go to FULL.
  - FULL (fill=NIBBLES, waiting for the slot):
    - When the slot becomes free, transfer the word. If a beat arrives in that same cycle, it becomes beat 0 of the new word and goes to ACCUM.
    - If a beat arrives while the slot is not free, it is dropped and overflow is set.
- Latency: the beat that completes a word appears as out_valid=1 one cycle later.
- Output handshake:
  - A word holds stable while out_valid && !out_ready.
  - A transfer occurs on out_valid && out_ready.
  - A back-to-back word may load on the same edge as the transfer.
- Flush:
  - flush with fill=0, or in FULL, is a no-op.
  - Otherwise flush sets flush_pend.
  - If in_valid arrives in the flush cycle, that beat is appended first.
  - While flush_pend is set, beats keep appending. On the first cycle the slot is free, the word is transferred with out_count=fill and flush_pend is cleared.
  - If fill reaches NIBBLES first, the word is emitted as a normal full word and flush_pend is cleared.
- Packing:
  - MSB_FIRST=1: beat k occupies bits [OUT_W-1-k*IN_W -: IN_W].
  - MSB_FIRST=0: beat k occupies bits [k*IN_W +: IN_W].
  - Unfilled slots of a partial word are zero.
  - out_count=NIBBLES for full words.
- Overflow:
  - Sticky; set on any dropped beat.
  - Cleared by ovf_clr or rst.
  - A drop in the same cycle as ovf_clr leaves overflow=1.
- busy = (fill!=0) || out_valid.

Optional Feature:
- Macro: NIBBLE_ASM_DROP_CNT_EN.
- When defined:
  - Adds output `drop_count [DROP_CNT_W-1:0]`, which increments once per dropped beat.
  - The counter saturates at all-ones.
  - It is cleared by rst or ovf_clr. If a drop coincides with ovf_clr, the counter loads 1.
- When not defined: the port and counter are absent; all other behaviour is unchanged.

Decomposition:
- Package `nibble_asm_pkg` holds:
  - the state enum (EMPTY, ACCUM, FULL);
  - a clog2-style width function for `out_count`;
  - a packing-offset function keyed on MSB_FIRST.
- One natural sub-module: `nibble_asm_outreg`, a single-entry valid/ready holding register carrying {out_count, out_data}.

Test Plan:
All scenarios use NIBBLES=4 and MSB_FIRST=1 unless stated otherwise.
1. Basic pack:
   - Stimulus: beats 1,2,3,4 on consecutive cycles, out_ready=1.
   - Response: out_data=16'h1234, out_count=4, out_valid one cycle after beat 4, pulsing for 1 cycle.
2. Backpressure and drop:
   - Stimulus: beats A,B,C,D,E,F,0,1,5 with out_ready=0, then out_ready=1.
   - Response: word 16'hABCD is held. 16'hEF01 sits in FULL. Beat 5 is dropped: overflow=1 and drop_count=1 (with the macro). After out_ready=1, the outputs are ABCD then EF01; no word contains 5.
3. Flush partial:
   - Stimulus: beats 7,8, then a flush pulse.
   - Response: 16'h7800 with out_count=2.
   - Flush with fill=0 produces no output.
   - Flush coincident with beat 9 after beats 1,2 produces 16'h1290 with out_count=3.
4. Reset mid-word:
   - Stimulus: beats 1,2,3, then rst for 1 cycle, then beats C,D,E,F.
   - Response: exactly one word, 16'hCDEF, out_count=4.
5. Overflow clear:
   - Stimulus: after scenario 2, pulse ovf_clr.
   - Response: overflow=0 and drop_count=0. Repeat with a drop in the same cycle as ovf_clr: overflow=1 and drop_count=1.
6. LSB ordering (MSB_FIRST=0):
   - Stimulus: beats 1,2,3,4; then beats 1,2 followed by a flush.
   - Response: 16'h4321 for the full word; 16'h0021 with out_count=2 for the flushed partial.
